// File: rtl/start_scheduler.sv
`default_nettype none
// ============================================================================
// start_scheduler : queues start requests and issues them one at a time to a
//   4-state sequencer, with a per-phase watchdog and sticky timeout flag.
// Rev 1.0
// ============================================================================
module start_scheduler #(
  parameter int MAX_PEND = 7,
  parameter int TIMEOUT  = 15
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] seq_state,
  output logic       start,
  output logic       busy,
  output logic [2:0] pending,
  output logic       done_pulse,
  output logic       timeout_err,
  input  logic       clr_err
);

  localparam logic [2:0] C_MAX_PEND = 3'(MAX_PEND);
  localparam logic [3:0] C_WD_LAST  = 4'(TIMEOUT - 1);
  localparam logic [1:0] C_SEQ_IDLE = 2'b00;
  localparam logic [1:0] C_SEQ_ACK  = 2'b01;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_RUN   = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] pending_q, pending_d;
  logic [3:0] wd_q, wd_d;
  logic       done_q, done_d;
  logic       err_q, err_d;
  logic       w_take;
  logic       w_accept;
  logic       w_expire;

  assign req_ready = (pending_q < C_MAX_PEND);

  always_comb begin
    state_d  = state_q;
    wd_d     = 4'd0;
    done_d   = 1'b0;
    err_d    = err_q;
    w_accept = 1'b0;
    w_expire = 1'b0;
    w_take   = req_valid & req_ready;

    case (state_q)
      S_IDLE: begin
        if ((pending_q != 3'd0) && (seq_state == C_SEQ_IDLE) && !err_q) begin
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        wd_d = wd_q + 4'd1;
        // An expiring watchdog wins over an accept seen on the same edge.
        if (wd_q == C_WD_LAST) begin
          w_expire = 1'b1;
          state_d  = S_IDLE;
          wd_d     = 4'd0;
        end else if (seq_state == C_SEQ_ACK) begin
          w_accept = 1'b1;
          state_d  = S_RUN;
          wd_d     = 4'd0;
        end
      end
      S_RUN: begin
        wd_d = wd_q + 4'd1;
        if (wd_q == C_WD_LAST) begin
          w_expire = 1'b1;
          state_d  = S_IDLE;
          wd_d     = 4'd0;
        end else if (seq_state == C_SEQ_IDLE) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
          wd_d    = 4'd0;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (w_expire) begin
      err_d = 1'b1;
    end else if (clr_err) begin
      err_d = 1'b0;
    end

    pending_d = pending_q + {2'b00, w_take} - {2'b00, w_accept};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      pending_q <= 3'd0;
      wd_q      <= 4'd0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      wd_q      <= wd_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign start       = (state_q == S_ISSUE);
  assign busy        = (state_q != S_IDLE);
  assign pending     = pending_q;
  assign done_pulse  = done_q;
  assign timeout_err = err_q;

endmodule
`default_nettype wire

// File: tb/tb_start_scheduler.sv
`default_nettype none
// ============================================================================
// tb_start_scheduler : directed scenarios plus randomized traffic, checked
//   every cycle against a behavioural model of the scheduler. Rev 1.0
// ============================================================================
module tb_start_scheduler;

  localparam int MAXP = 7;
  localparam int TO   = 15;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [1:0] seq_state = 2'b00;
  logic       start;
  logic       busy;
  logic [2:0] pending;
  logic       done_pulse;
  logic       timeout_err;
  logic       clr_err = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  start_scheduler #(.MAX_PEND(MAXP), .TIMEOUT(TO)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .seq_state  (seq_state),
    .start      (start),
    .busy       (busy),
    .pending    (pending),
    .done_pulse (done_pulse),
    .timeout_err(timeout_err),
    .clr_err    (clr_err)
  );

  always #5 clk = ~clk;

  // Model: a sequence is "in flight" from launch until done or abort;
  // "acked" once the sequencer has shown 01; age counts cycles in the phase.
  int m_pend = 0;
  bit m_in = 0, m_ack = 0, m_err = 0, m_done = 0;
  int m_age = 0;

  always @(posedge clk or negedge reset_n) begin : p_model
    bit acc, fin, abort, take, launch, n_in, n_ack, n_err;
    int n_age;
    if (!reset_n) begin
      m_pend <= 0; m_in <= 0; m_ack <= 0; m_err <= 0; m_done <= 0; m_age <= 0;
    end else begin
      acc = 0; fin = 0; abort = 0;
      n_in = m_in; n_ack = m_ack; n_err = m_err; n_age = m_age;
      take   = req_valid && (m_pend < MAXP);
      launch = !m_in && (m_pend > 0) && (seq_state == 2'd0) && !m_err;
      if (m_in) begin
        n_age = m_age + 1;
        if (n_age >= TO) abort = 1;
        else if (!m_ack && seq_state == 2'd1) acc = 1;
        else if (m_ack && seq_state == 2'd0) fin = 1;
      end
      if (abort) n_err = 1;
      else if (clr_err) n_err = 0;
      if (abort || fin) n_in = 0;
      else if (launch) begin n_in = 1; n_ack = 0; n_age = 0; end
      if (acc) begin n_ack = 1; n_age = 0; end
      m_pend <= m_pend + int'(take) - int'(acc);
      m_in   <= n_in;
      m_ack  <= n_ack;
      m_err  <= n_err;
      m_age  <= n_age;
      m_done <= fin;
    end
  end

  task automatic model_check();
    bit e_start, e_busy, e_rdy;
    e_start = m_in && !m_ack;
    e_busy  = m_in;
    e_rdy   = (m_pend < MAXP);
    n_cmp++;
    if (start !== e_start || busy !== e_busy || int'(pending) != m_pend ||
        done_pulse !== m_done || timeout_err !== m_err || req_ready !== e_rdy) begin
      n_bad++;
      $display("FAIL model t=%0t: got start=%b busy=%b pend=%0d done=%b err=%b rdy=%b, want %b %b %0d %b %b %b",
               $time, start, busy, pending, done_pulse, timeout_err, req_ready,
               e_start, e_busy, m_pend, m_done, m_err, e_rdy);
    end
  endtask

  task automatic lit(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
    model_check();
  endtask

  initial begin
    int n, dones;

    repeat (2) @(posedge clk);
    #2;
    lit("rst_pending", int'(pending), 0);
    lit("rst_ready", int'(req_ready), 1);
    lit("rst_busy", int'(busy), 0);
    reset_n = 1'b1;

    // Single request through a full 00->01->10->11->00 sequence
    req_valid = 1'b1; cyc(); req_valid = 1'b0;
    lit("one_pending", int'(pending), 1);
    cyc();
    lit("one_start", int'(start), 1);
    seq_state = 2'd1; cyc();
    lit("one_accept_pend", int'(pending), 0);
    lit("one_accept_start", int'(start), 0);
    seq_state = 2'd2; cyc();
    seq_state = 2'd3; cyc();
    seq_state = 2'd0; cyc();
    lit("one_done", int'(done_pulse), 1);
    lit("one_idle_busy", int'(busy), 0);
    cyc();
    lit("one_done_cleared", int'(done_pulse), 0);

    // Saturation with a stalled sequencer
    seq_state = 2'd3; req_valid = 1'b1;
    repeat (10) cyc();
    req_valid = 1'b0;
    lit("sat_pending", int'(pending), 7);
    lit("sat_ready", int'(req_ready), 0);
    lit("sat_busy", int'(busy), 0);

    // Simultaneous request and accept with pending=3
    reset_n = 1'b0; cyc(); reset_n = 1'b1;
    req_valid = 1'b1; repeat (3) cyc(); req_valid = 1'b0;
    seq_state = 2'd0; cyc();
    lit("both_issue_start", int'(start), 1);
    seq_state = 2'd1; req_valid = 1'b1; cyc(); req_valid = 1'b0;
    lit("both_pending", int'(pending), 3);

    // Asynchronous reset mid-RUN with pending=4
    req_valid = 1'b1; cyc(); req_valid = 1'b0;
    seq_state = 2'd2;
    lit("midrun_pending", int'(pending), 4);
    lit("midrun_busy", int'(busy), 1);
    #1 reset_n = 1'b0;
    #1;
    lit("async_pending", int'(pending), 0);
    lit("async_busy", int'(busy), 0);
    lit("async_start", int'(start), 0);
    lit("async_ready", int'(req_ready), 1);
    @(posedge clk); #2; reset_n = 1'b1;
    cyc();
    lit("post_rst_pending", int'(pending), 0);

    // Watchdog in ISSUE, then clear and re-issue
    seq_state = 2'd3; req_valid = 1'b1; repeat (2) cyc(); req_valid = 1'b0;
    seq_state = 2'd0; cyc();
    n = 0;
    for (int i = 0; i < 20 && start; i++) begin
      n++;
      cyc();
    end
    lit("to_start_cycles", n, 15);
    lit("to_err", int'(timeout_err), 1);
    lit("to_pending", int'(pending), 2);
    cyc();
    lit("to_hold_idle", int'(start), 0);
    clr_err = 1'b1; cyc(); clr_err = 1'b0;
    lit("clr_err", int'(timeout_err), 0);
    cyc();
    lit("clr_reissue", int'(start), 1);
    seq_state = 2'd1; cyc();
    seq_state = 2'd0; cyc();
    lit("clr_done", int'(done_pulse), 1);
    lit("clr_pending", int'(pending), 1);

    // Three queued requests served back to back
    reset_n = 1'b0; cyc(); reset_n = 1'b1;
    seq_state = 2'd3; req_valid = 1'b1; repeat (3) cyc(); req_valid = 1'b0;
    lit("b2b_pending", int'(pending), 3);
    dones = 0;
    for (int k = 0; k < 3; k++) begin
      seq_state = 2'd0;
      for (int i = 0; i < 4 && !start; i++) cyc();
      lit("b2b_start", int'(start), 1);
      seq_state = 2'd1; cyc();
      seq_state = 2'd2; cyc();
      seq_state = 2'd0; cyc();
      if (done_pulse) dones++;
    end
    lit("b2b_dones", dones, 3);
    lit("b2b_pending_end", int'(pending), 0);

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      req_valid = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 9) < 3) seq_state = 2'($urandom_range(0, 3));
      clr_err = ($urandom_range(0, 24) == 0);
      reset_n = ($urandom_range(0, 399) != 0);
      cyc();
    end
    reset_n = 1'b1; clr_err = 1'b0; req_valid = 1'b0;
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/start_scheduler.md
START_SCHEDULER -- requirements
Module: start_scheduler

Interface
REQ-001 SHALL have parameter MAX_PEND, default 7: maximum queued start requests, range 1..7.
REQ-002 SHALL have parameter TIMEOUT, default 15: cycles allowed in ISSUE or RUN before abort, range 2..15.
REQ-003 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n, input, 1: reset, asynchronous and active-low.
REQ-005 SHALL have port req_valid, input, 1: a start request is offered.
REQ-006 SHALL have port req_ready, output, 1: a request is accepted this cycle if req_valid=1.
REQ-007 SHALL have port seq_state, input, 2: current state of the downstream 4-state sequencer (00 idle, 01, 10, 11).
REQ-008 SHALL have port start, output, 1: start strobe to the sequencer's start input.
REQ-009 SHALL have port busy, output, 1: 1 whenever the FSM is not IDLE.
REQ-010 SHALL have port pending, output, 3: number of queued, not-yet-issued requests.
REQ-011 SHALL have port done_pulse, output, 1: one-cycle pulse when a sequence completes.
REQ-012 SHALL have port timeout_err, output, 1: sticky watchdog error flag.
REQ-013 SHALL have port clr_err, input, 1: synchronous clear of timeout_err.

Function
REQ-014 SHALL drive req_ready = (pending < MAX_PEND), combinationally from the registered count.
REQ-015 SHALL increment pending on req_valid & req_ready, decrement on an issue-accept (REQ-019), and leave it unchanged when both happen in the same cycle.
REQ-016 SHALL implement a 3-state FSM: IDLE, ISSUE, RUN, with all outputs except req_ready registered or decoded from state registers only.
REQ-017 SHALL transition IDLE->ISSUE when pending>0, seq_state=00 and timeout_err=0; otherwise remain in IDLE.
REQ-018 SHALL assert start=1 for exactly the cycles the FSM is in ISSUE; start=0 in all other states.
REQ-019 SHALL transition ISSUE->RUN on the first edge at which seq_state=01 (issue-accept), decrementing pending on that edge.
REQ-020 SHALL transition RUN->IDLE on the first edge at which seq_state=00, registering done_pulse=1 for the following cycle only.
REQ-021 SHALL keep a 4-bit watchdog counter, cleared on every state change and at IDLE, incremented every cycle in ISSUE or RUN.
REQ-022 SHALL, when the watchdog reaches TIMEOUT in ISSUE or RUN, set timeout_err=1, go to IDLE, leave pending unchanged, and not pulse done_pulse.
REQ-023 SHALL clear timeout_err on clr_err=1; a timeout set in the same cycle SHALL win over clr_err.
REQ-024 SHALL hold in IDLE while timeout_err=1, still accepting requests up to MAX_PEND.
REQ-025 SHALL, in RUN, ignore seq_state values 01, 10, 11 (no ordering check); only 00 ends RUN.
REQ-026 SHALL, if seq_state=00 is seen in ISSUE before any 01, stay in ISSUE with start held high.

Reset
REQ-027 SHALL, while reset_n=0, force FSM=IDLE, pending=0, watchdog=0, start=0, busy=0, done_pulse=0, timeout_err=0, independent of clk.
REQ-028 SHALL discard queued requests and any in-flight sequence on reset, including reset asserted mid-RUN; req_ready=1 immediately after reset.

Verification
REQ-029 SHALL pass: one req_valid pulse with model sequencer in 00 -> pending 1, start high next cycle, seq 01/10/11/00, done_pulse once, pending 0, busy 0.
REQ-030 SHALL pass: req_valid held 10 cycles with sequencer stalled in 11 -> pending saturates at 7, req_ready=0, no lost or extra count.
REQ-031 SHALL pass: req_valid and issue-accept on the same edge with pending=3 -> pending stays 3.
REQ-032 SHALL pass: sequencer never leaves 00 after start -> after 15 cycles in ISSUE, timeout_err=1, start=0, pending unchanged; clr_err -> ISSUE re-entered.
REQ-033 SHALL pass: reset_n driven low mid-RUN with pending=4 -> all outputs at reset values asynchronously, pending=0 after release.
REQ-034 SHALL pass: three queued requests -> three back-to-back start/done_pulse pairs, each start only while seq_state=00 at entry.
